dram_refresh_arb: RTL
=====================

Name: dram_refresh_arb

Overview:
Refresh scheduler that sits directly upstream of the DRAM timing controller.
- Generates periodic refresh ticks from the system clock and keeps a count of owed refreshes.
- Issues refresh requests to the controller using a req/ack/done handshake.
- Hides refreshes in CPU bus-idle gaps; forces them when the backlog approaches its limit.
- Also provides status outputs for debug and the glue-logic status register.

Parameters:
REFRESH_DIV, 250, clocks between refresh ticks (15.6 us at 16 MHz); legal range 2..65535
MAX_PENDING, 4, owed-refresh ceiling; legal range 2..7
TIMEOUT, 15, max clocks waiting in REQ or BUSY before fault; legal range 1..255

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
refEnable  in  1  1 = refresh ticks run; 0 = divider frozen, no new ticks
nCpuAS  in  1  CPU address strobe, active low
nMemCE  in  1  DRAM chip enable decode, active low
refAck  in  1  one-clock pulse from controller: refresh accepted (entering its refresh CAS state)
refDone  in  1  one-clock pulse from controller: refresh sequence complete
clearFault  in  1  one-clock pulse clearing overflow and timeout flags
refReq  out  1  refresh request to controller
refUrgent  out  1  backlog high; controller must take refresh ahead of the next CPU cycle
pendCount  out  3  owed refreshes, 0..MAX_PENDING
refOverflow  out  1  sticky: tick lost at saturation
refTimeout  out  1  sticky: handshake exceeded TIMEOUT

Behaviour:
Reset:
- All outputs 0; divider 0; pendCount 0; state IDLE; timeout counter 0.
- Reset asserted mid-handshake returns immediately to IDLE with refReq=0. Owed refreshes are discarded.

Divider:
- Counts 0..REFRESH_DIV-1 while refEnable=1 and wraps to 0.
- tick is a one-clock internal pulse when the count equals REFRESH_DIV-1.
- refEnable=0 holds the count and suppresses tick. pendCount is retained and still drained.

Pending counter (registered, saturating):
- tick only: +1 if pendCount<MAX_PENDING. Otherwise unchanged and refOverflow<=1.
- refAck only: -1. refAck with pendCount=0 is ignored.
- tick and refAck in the same clock: unchanged. refOverflow is not set even at MAX_PENDING.

refUrgent:
- Registered; equals (pendCount >= MAX_PENDING-1), evaluated on the next-state value.

Handshake FSM, states IDLE, REQ, BUSY:
- IDLE -> REQ when next pendCount>0 AND (refUrgent OR bus idle).
  - Bus idle = nCpuAS=1 OR nMemCE=1, sampled this clock.
  - refReq<=1 on entry.
- REQ:
  - refReq held at 1 until refAck, and never withdrawn once raised.
  - refAck -> BUSY, refReq<=0 in the same edge, pendCount decremented.
- BUSY: refDone -> IDLE.
  - From IDLE the FSM can re-request the next clock if the backlog remains.
- refAck outside REQ: ignored, no decrement. refDone outside BUSY: ignored.
- Simultaneous refAck and refDone in REQ: go to BUSY; refDone is ignored.

Timeout:
- Counter clears on every state change and counts while in REQ or BUSY.
- Reaching TIMEOUT sets refTimeout and forces IDLE with refReq=0.
- pendCount is untouched unless refAck already occurred.

Sticky flags:
- clearFault clears refOverflow and refTimeout.
- clearFault coincident with a new set event: set wins.

Latency:
- A tick with the bus idle and pendCount=0 gives refReq=1 one clock after the tick edge.

Width:
- Divider width = clog2(REFRESH_DIV); timeout counter width = clog2(TIMEOUT+1).
- pendCount is zero-extended to 3 bits.

Test Plan:
1. Reset with REFRESH_DIV=8, refEnable=1, nCpuAS=1, controller acks 2 clocks after refReq and sends refDone 3 clocks later -> refReq rises one clock after each tick (every 8 clocks); pendCount stays 0/1; no flags.
2. nCpuAS=0, nMemCE=0 held, no acks -> pendCount 1,2,3; refReq stays 0 until pendCount=3, then refUrgent=1 and refReq=1 despite bus busy.
3. Same as 2 but continue to 5 ticks with no ack -> pendCount saturates at 4, refOverflow=1 on fifth tick; clearFault -> refOverflow=0.
4. tick and refAck in the same clock with pendCount=2 -> pendCount stays 2; FSM in BUSY; refReq=0.
5. refReq asserted, no refAck for 15 clocks (TIMEOUT=15) -> refTimeout=1, FSM IDLE, pendCount unchanged; next idle clock re-requests.
6. Assert reset while in BUSY with pendCount=3 -> all outputs 0 asynchronously; after release the divider restarts from 0 and the first refReq appears after REFRESH_DIV clocks.

Source files
------------

// File: rtl/dram_refresh_arb_if.sv
// -----------------------------------------------------------------------------
// dram_refresh_arb_if
// Signal bundle between the refresh scheduler and its surroundings (CPU bus
// decode, DRAM timing controller, glue-logic status register).
//
//   refEnable   ctrl  -> arb   1 = refresh ticks run
//   nCpuAS      cpu   -> arb   CPU address strobe, active low
//   nMemCE      dec   -> arb   DRAM chip enable decode, active low
//   refAck      ctl   -> arb   one-clock pulse: refresh accepted
//   refDone     ctl   -> arb   one-clock pulse: refresh sequence complete
//   clearFault  sw    -> arb   one-clock pulse: clear sticky flags
//   refReq      arb   -> ctl   refresh request
//   refUrgent   arb   -> ctl   backlog high, refresh before next CPU cycle
//   pendCount   arb   -> stat  owed refreshes
//   refOverflow arb   -> stat  sticky: tick lost at saturation
//   refTimeout  arb   -> stat  sticky: handshake timed out
//
// slave  : the view used by the scheduler itself
// master : the view used by whatever drives the scheduler (controller/bench)
// -----------------------------------------------------------------------------
interface dram_refresh_arb_if;
   logic       refEnable;
   logic       nCpuAS;
   logic       nMemCE;
   logic       refAck;
   logic       refDone;
   logic       clearFault;
   logic       refReq;
   logic       refUrgent;
   logic [2:0] pendCount;
   logic       refOverflow;
   logic       refTimeout;

   modport slave (
      input  refEnable, nCpuAS, nMemCE, refAck, refDone, clearFault,
      output refReq, refUrgent, pendCount, refOverflow, refTimeout
   );

   modport master (
      output refEnable, nCpuAS, nMemCE, refAck, refDone, clearFault,
      input  refReq, refUrgent, pendCount, refOverflow, refTimeout
   );
endinterface

// File: rtl/dram_refresh_arb.sv
// -----------------------------------------------------------------------------
// dram_refresh_arb
// Refresh scheduler in front of the DRAM timing controller. A free-running
// divider produces refresh ticks; owed refreshes are counted in a saturating
// backlog and issued through a req/ack/done handshake. Refreshes are hidden in
// CPU bus-idle gaps and forced once the backlog is one short of its ceiling.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of dram_refresh_arb_if (handshake, bus sense, status)
//
// Parameters:
//   REFRESH_DIV  clocks between refresh ticks (2..65535)
//   MAX_PENDING  owed-refresh ceiling (2..7)
//   TIMEOUT      max clocks in REQ or BUSY before a fault (1..255)
// -----------------------------------------------------------------------------
module dram_refresh_arb #(
   parameter int unsigned REFRESH_DIV = 250,
   parameter int unsigned MAX_PENDING = 4,
   parameter int unsigned TIMEOUT     = 15
) (
   input logic               clock,
   input logic               reset,
   dram_refresh_arb_if.slave bus
);

   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [2:0]       PEND_MAX = 3'(MAX_PENDING);
   localparam logic [2:0]       URG_TH   = 3'(MAX_PENDING - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_BUSY = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [2:0]       pend_q, pend_d;
   logic             urgent_q, urgent_d;
   logic             ovf_q, ovf_d;
   logic             tflag_q, tflag_d;

   logic tick;
   logic ack_take;
   logic done_take;
   logic bus_idle;
   logic tmo_hit;
   logic ovf_set;
   logic tmo_set;

   // ---------------------------------------------------------------------------
   // Qualified events
   // ---------------------------------------------------------------------------
   assign tick      = bus.refEnable && (div_q == DIV_LAST);
   assign ack_take  = bus.refAck && (state_q == S_REQ) && (pend_q != 3'd0);
   assign done_take = bus.refDone && (state_q == S_BUSY);
   assign bus_idle  = bus.nCpuAS | bus.nMemCE;
   // The counter would reach TIMEOUT on this edge; the FSM leaves instead.
   assign tmo_hit   = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

   // ---------------------------------------------------------------------------
   // Divider and backlog
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      div_d   = div_q;
      pend_d  = pend_q;
      ovf_set = 1'b0;

      if (bus.refEnable) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      // A tick and an accepted refresh in the same clock cancel out, so a
      // saturated backlog does not count that tick as lost.
      if (tick && !ack_take) begin
         if (pend_q < PEND_MAX) begin
            pend_d = pend_q + 3'd1;
         end else begin
            ovf_set = 1'b1;
         end
      end else if (!tick && ack_take) begin
         pend_d = pend_q - 3'd1;
      end

      urgent_d = (pend_d >= URG_TH);
   end

   // ---------------------------------------------------------------------------
   // Handshake FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of process order.
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Handshake FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      tmo_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Urgency uses the registered flag; the backlog uses its
            // next-state value so a fresh tick can be requested at once.
            if ((pend_d != 3'd0) && (urgent_q || bus_idle)) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Acceptance beats a coincident timeout and any refDone.
            if (ack_take) begin
               state_d = S_BUSY;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
               tmo_set = 1'b1;
            end
         end
         S_BUSY: begin
            if (done_take) begin
               state_d = S_IDLE;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
               tmo_set = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Handshake FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.refReq = (state_q == S_REQ);
   end

   // ---------------------------------------------------------------------------
   // Timeout counter and sticky flags
   // ---------------------------------------------------------------------------
   always_comb begin
      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (state_q != S_IDLE) begin
         tmo_d = tmo_q + 1'b1;
      end else begin
         tmo_d = '0;
      end

      // A new set event wins over a coincident clear.
      ovf_d   = ovf_set | (ovf_q & ~bus.clearFault);
      tflag_d = tmo_set | (tflag_q & ~bus.clearFault);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: reset clears all state, so the backlog of owed refreshes
         // is discarded along with any handshake in progress.
         div_q    <= '0;
         tmo_q    <= '0;
         pend_q   <= 3'd0;
         urgent_q <= 1'b0;
         ovf_q    <= 1'b0;
         tflag_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         tmo_q    <= tmo_d;
         pend_q   <= pend_d;
         urgent_q <= urgent_d;
         ovf_q    <= ovf_d;
         tflag_q  <= tflag_d;
      end
   end

   assign bus.refUrgent   = urgent_q;
   assign bus.pendCount   = pend_q;
   assign bus.refOverflow = ovf_q;
   assign bus.refTimeout  = tflag_q;

endmodule
